// File: rtl/adder_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : adder_share_arbiter (with helper number_adder)             |
// | Description : Round-robin sharing of one 32-bit ripple adder between     |
// |               NUM_REQ valid/ready requesters, single output register     |
// |               tagged with the winning requester ID.                      |
// | Options     : define ADDER_ARB_OVF_EN to add the registered rsp_ovf port |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

// Plain 32-bit ripple-carry adder; kept as its own module so the datapath
// stays recognisable as the shared resource.
module number_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] w_carry;

  assign w_carry[0] = cin;

  // One full adder per bit, carry rippling upward.
  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    assign sum[gi]         = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = w_carry[32];
endmodule

module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_sum,
  output logic                  rsp_cout,
  output logic [ID_W-1:0]       rsp_id
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                  rsp_ovf
`endif
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     w_ptr_nxt;

  logic                w_any;
  logic                w_slot_free;
  logic                w_do_grant;
  logic                w_hi_found;
  logic [ID_W-1:0]     w_hi_idx;
  logic [ID_W-1:0]     w_lo_idx;
  logic [ID_W-1:0]     w_win_idx;
  logic [NUM_REQ-1:0]  w_win_oh;

  logic [31:0]         w_a;
  logic [31:0]         w_b;
  logic                w_cin;
  logic [31:0]         w_sum;
  logic                w_cout;

  assign rsp_valid   = (r_state == ST_FULL);
  assign w_slot_free = !rsp_valid | rsp_ready;
  assign w_any       = |req_valid;
  // Reset forces the grant off so nothing is accepted during the reset cycle.
  assign w_do_grant  = w_any & w_slot_free & !rst;

  // Round-robin search: lowest valid index at or above ptr, else lowest valid
  // index overall (the wrap-around case). Iterating downward lets the last hit
  // be the lowest one.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_idx = ID_W'(i);
        if (ID_W'(i) >= r_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = ID_W'(i);
        end
      end
    end
    w_win_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  // Winner decoded to one-hot; it steers both the data mux and the grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign w_win_oh[gi] = w_any & (w_win_idx == ID_W'(gi));
  end

  assign req_ready = w_win_oh & {NUM_REQ{w_do_grant}};

  // AND-OR operand mux driven by the one-hot winner (no priority on data).
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_a   = w_a   | ({32{w_win_oh[i]}} & req_a[i*32 +: 32]);
      w_b   = w_b   | ({32{w_win_oh[i]}} & req_b[i*32 +: 32]);
      w_cin = w_cin | (w_win_oh[i] & req_cin[i]);
    end
  end

  number_adder u_adder (
    .a    (w_a),
    .b    (w_b),
    .cin  (w_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Pointer advances to the requester after the one just granted.
  assign w_ptr_nxt = (w_win_idx == ID_W'(NUM_REQ - 1)) ? '0 : (w_win_idx + ID_W'(1));

  // Result-register occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next occupancy: a grant always fills the slot (even while draining),
  // a drain without a grant empties it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_do_grant) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (!w_do_grant && rsp_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Result payload and round-robin pointer load only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else if (w_do_grant) begin
      r_ptr    <= w_ptr_nxt;
      rsp_sum  <= w_sum;
      rsp_cout <= w_cout;
      rsp_id   <= w_win_idx;
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic w_ovf;

  // Signed overflow: like-signed operands producing a sum of the other sign.
  assign w_ovf = (w_a[31] == w_b[31]) & (w_sum[31] != w_a[31]);

  // Overflow flag travels with the rest of the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_ovf <= 1'b0;
    end else if (w_do_grant) begin
      rsp_ovf <= w_ovf;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_adder_share_arbiter                                     |
// | Description : Scoreboard bench for adder_share_arbiter (NUM_REQ=4)       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_adder_share_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    req_cin;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_sum;
  logic            rsp_cout;
  logic [IW-1:0]   rsp_id;
`ifdef ADDER_ARB_OVF_EN
  logic            rsp_ovf;
`endif

  adder_share_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
`ifdef ADDER_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   sum;
    logic          cout;
    logic [IW-1:0] id;
    logic          ovf;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   errors  = 0;

  // Reference model state: next requester to favour and result occupancy.
  int   m_ptr       = 0;
  bit   m_valid     = 1'b0;
  bit   m_after_rst = 1'b1;

  function automatic logic [N*32-1:0] put(input logic [N*32-1:0] base, input int k,
                                          input logic [31:0] val);
    logic [N*32-1:0] r;
    r = base;
    r[k*32 +: 32] = val;
    return r;
  endfunction

  // Drive one cycle of stimulus, check the combinational grant and the
  // visible occupancy, then advance the model to the state after the edge.
  task automatic apply(input logic [N-1:0] v, input logic [N*32-1:0] a,
                       input logic [N*32-1:0] b, input logic [N-1:0] cin,
                       input bit rdy, input bit r);
    int           win;
    logic [N-1:0] exp_ready;
    logic [32:0]  full;
    logic [31:0]  ak, bk;
    exp_t         e;
    @(negedge clk);
    #1;
    rst = r; req_valid = v; req_a = a; req_b = b; req_cin = cin; rsp_ready = rdy;
    #1;
    vectors++;
    if (rsp_valid !== m_valid) begin
      errors++;
      $display("FAIL rsp_valid: got %b expected %b at %0t", rsp_valid, m_valid, $time);
    end
    if (m_after_rst) begin
      vectors++;
      if (rsp_sum !== 32'h0 || rsp_cout !== 1'b0 || rsp_id !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got sum=%h cout=%b id=%0d expected all zero",
                 rsp_sum, rsp_cout, rsp_id);
      end
    end
    win = -1;
    if (!r && (!m_valid || rdy)) begin
      for (int off = 0; off < N; off++) begin
        int k;
        k = (m_ptr + off) % N;
        if (win < 0 && v[k]) win = k;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    vectors++;
    if (req_ready !== exp_ready) begin
      errors++;
      $display("FAIL req_ready: got %b expected %b at %0t", req_ready, exp_ready, $time);
    end
    if (r) begin
      expq.delete();
      m_ptr   = 0;
      m_valid = 1'b0;
    end else if (win >= 0) begin
      ak     = a[win*32 +: 32];
      bk     = b[win*32 +: 32];
      full   = {1'b0, ak} + {1'b0, bk} + {32'h0, cin[win]};
      e.sum  = full[31:0];
      e.cout = full[32];
      e.id   = IW'(win);
      e.ovf  = (ak[31] == bk[31]) && (full[31] != ak[31]);
      expq.push_back(e);
      m_ptr   = (win + 1) % N;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_after_rst = r;
  endtask

  // Monitor: a result leaving on a handshake is compared with the oldest
  // expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst !== 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        vectors++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got sum=%h id=%0d expected none", rsp_sum, rsp_id);
        end else begin
          e = expq.pop_front();
          if (rsp_sum !== e.sum || rsp_cout !== e.cout || rsp_id !== e.id) begin
            errors++;
            $display("FAIL result: got sum=%h cout=%b id=%0d expected sum=%h cout=%b id=%0d",
                     rsp_sum, rsp_cout, rsp_id, e.sum, e.cout, e.id);
          end
`ifdef ADDER_ARB_OVF_EN
          if (rsp_ovf !== e.ovf) begin
            errors++;
            $display("FAIL ovf: got %b expected %b (sum=%h)", rsp_ovf, e.ovf, e.sum);
          end
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*32-1:0] a, b;
    logic [N-1:0]    v;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;

    // Reset with every requester asking.
    for (int i = 0; i < N; i++) begin
      a = put(a, i, $urandom); b = put(b, i, $urandom);
    end
    apply(4'hF, a, b, 4'h0, 1'b1, 1'b1);
    apply(4'hF, a, b, 4'h0, 1'b1, 1'b1);
    apply(4'hF, a, b, 4'h0, 1'b1, 1'b0);

    // Single adds.
    a = '0; b = '0;
    apply(4'b0100, put(a, 2, 32'h0000_00FF), put(b, 2, 32'h1), 4'b0000, 1'b1, 1'b0);
    apply(4'b0010, put(a, 1, 32'hFFFF_FFFF), put(b, 1, 32'h0), 4'b0010, 1'b1, 1'b0);
    apply(4'b0000, a, b, 4'b0000, 1'b1, 1'b0);

    // Round-robin with all requesters valid.
    apply(4'h0, a, b, 4'h0, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        a = put(a, i, $urandom); b = put(b, i, $urandom);
      end
      apply(4'hF, a, b, 4'($urandom), 1'b1, 1'b0);
    end
    apply(4'h0, a, b, 4'h0, 1'b1, 1'b0);

    // Backpressure with requesters 0 and 3.
    apply(4'h0, a, b, 4'h0, 1'b1, 1'b1);
    apply(4'b1001, a, b, 4'b0000, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) apply(4'b1001, a, b, 4'b0000, 1'b0, 1'b0);
    apply(4'b1001, a, b, 4'b1001, 1'b1, 1'b0);
    apply(4'b0000, a, b, 4'b0000, 1'b1, 1'b0);

    // Reset while a result is held.
    apply(4'b0100, a, b, 4'b0000, 1'b1, 1'b0);
    apply(4'b0000, a, b, 4'b0000, 1'b0, 1'b0);
    apply(4'b0000, a, b, 4'b0000, 1'b0, 1'b1);
    apply(4'hF, a, b, 4'h0, 1'b1, 1'b0);
    apply(4'h0, a, b, 4'h0, 1'b1, 1'b0);

    // Signed overflow corner operands.
    apply(4'b0001, put(a, 0, 32'h7FFF_FFFF), put(b, 0, 32'h1), 4'b0000, 1'b1, 1'b0);
    apply(4'b0001, put(a, 0, 32'h8000_0000), put(b, 0, 32'h8000_0000), 4'b0000, 1'b1, 1'b0);

    // Randomized traffic with random backpressure and edge operands.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0:       a = put(a, i, 32'hFFFF_FFFF);
          1:       a = put(a, i, 32'h7FFF_FFFF);
          default: a = put(a, i, $urandom);
        endcase
        b = put(b, i, ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom);
      end
      v = 4'($urandom);
      apply(v, a, b, 4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
    end

    // Drain anything still pending.
    for (int c = 0; c < 10; c++) apply(4'h0, a, b, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    #4;
    vectors++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding expected 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Shares one 32-bit ripple adder (`number_adder`) between `NUM_REQ` requesters using round-robin arbitration. Each requester presents operands with a valid/ready handshake. The winning request is added combinationally, and the result is captured in a single output register tagged with the requester ID. The block sits between the test-stimulus sources and the adder datapath in the adder tester, and is the only instantiator of `number_adder` there.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2–8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs on `req_valid[i] & req_ready[i]`.
- `req_a`  in  NUM_REQ*32  operand A; requester i uses bits [32i+31:32i].
- `req_b`  in  NUM_REQ*32  operand B, packed the same way as `req_a`.
- `req_cin`  in  NUM_REQ  carry-in per requester.
- `rsp_valid`  out  1  result register holds a valid result.
- `rsp_ready`  in  1  downstream accepts the result.
- `rsp_sum`  out  32  registered sum.
- `rsp_cout`  out  1  registered carry-out.
- `rsp_id`  out  ID_W  index of the requester that produced the result.
- `rsp_ovf`  out  1  signed overflow; present only with `ADDER_ARB_OVF_EN`.

## Operation
- **States:**
  - EMPTY: result register empty.
  - FULL: result register holds an undelivered result.
- **Slot free:** `slot_free = !rsp_valid | rsp_ready`.
- **Grant rule:**
  - If `slot_free` and any `req_valid` is set, grant the first requester whose valid bit is set, searching from `ptr` upward with wrap-around from `NUM_REQ-1` to 0.
  - `req_ready` is combinational: one-hot on the winner, zero otherwise.
  - If the slot is not free, all `req_ready` bits are 0.
- **Pointer:** on a grant to requester k, `ptr <= (k+1) mod NUM_REQ`. With no grant, `ptr` holds.
- **Adder inputs:** the adder always sees the winner's `a`, `b` and `cin`. The operand mux is one-hot/AND-OR, with no priority encoder on the data.
- **On a grant:** the result register loads `sum`, `cout` and `id=k`, and `rsp_valid <= 1`.
- **On a handshake without a new grant:** a `rsp_valid & rsp_ready` handshake with no new grant sets `rsp_valid <= 0`.
- **Simultaneous drain and grant:** the register reloads and `rsp_valid` stays 1. This gives full throughput of one add per cycle.
- **Output stability:** while `rsp_valid=1` and `rsp_ready=0`, all `rsp_*` outputs hold stable.
- **Arithmetic:** unsigned 32-bit with carry-in. `{rsp_cout, rsp_sum} = a + b + cin` and wraps modulo 2^33. Example: 0xFFFFFFFF + 0 + 1 gives sum 0, cout 1.
- **Reset:**
  - All outputs are 0: `rsp_valid`, `rsp_sum`, `rsp_cout`, `rsp_id`, `rsp_ovf`.
  - `ptr` is 0.
  - `req_ready` is 0 during the reset cycle; it is forced low while `rst=1`.
  - Reset asserted mid-operation discards any held result without delivering it.
- **Requester rule:** a requester must hold `a`, `b` and `cin` stable while `req_valid` is high and `req_ready` is low. It may withdraw `req_valid` before it is granted.

## Timing
- **Grant:** combinational in the same cycle as `req_valid`.
- **Result latency:** the result appears on `rsp_*` one cycle after the grant edge.
- **Critical path:** round-robin select, then operand mux, then the 32-bit ripple adder, then the result register. There is no extra pipelining.
- **Throughput:** one result per cycle while `rsp_ready=1`. After backpressure is released, the next grant occurs in the same cycle `rsp_ready` rises.
- **Fairness:** a continuously requesting requester is granted within `NUM_REQ` grants.

## Configuration
- **Macro:** `ADDER_ARB_OVF_EN`.
- **Defined:**
  - Adds the `rsp_ovf` port.
  - It is registered with the result: `rsp_ovf = (a[31]==b[31]) & (sum[31]!=a[31])`, using the granted operands.
  - Reset value is 0.
- **Undefined:** the port and its register are absent. All other behaviour is identical.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` for 2 cycles with all `req_valid=1`.
  - Required: `req_ready=0`, `rsp_valid=0`, `rsp_sum=0`.
  - Required: the first grant after release goes to requester 0.
- **Single add:**
  - Stimulus: requester 2 sends a=0x0000_00FF, b=0x0000_0001, cin=0.
  - Required: the next cycle shows `rsp_sum=0x100`, `rsp_cout=0`, `rsp_id=2`.
  - Stimulus: requester 1 sends a=0xFFFF_FFFF, b=0, cin=1.
  - Required: `rsp_sum=0`, `rsp_cout=1`, `rsp_id=1`.
- **Round-robin:**
  - Stimulus: all 4 requesters valid continuously with `rsp_ready=1`.
  - Required: IDs 0,1,2,3,0,1 on consecutive cycles, with `rsp_valid` high every cycle.
- **Backpressure:**
  - Stimulus: hold `rsp_ready=0` for 3 cycles while requesters 0 and 3 stay valid.
  - Required: after the first result, `req_ready=0` and outputs are stable.
  - Required: on release, the drain and the next grant (requester 3 if `ptr=1`) occur in the same cycle with no bubble.
- **Reset mid-operation:**
  - Stimulus: `rsp_valid=1` and `rsp_ready=0`, then assert `rst` for 1 cycle.
  - Required: `rsp_valid=0` after the reset edge, and `ptr=0`.
- **Overflow (with `ADDER_ARB_OVF_EN`):**
  - Stimulus: a=0x7FFF_FFFF, b=1, cin=0. Required: `rsp_ovf=1`, `rsp_sum=0x8000_0000`.
  - Stimulus: a=0x8000_0000, b=0x8000_0000. Required: `rsp_ovf=1`, `rsp_cout=1`.
